pkt_gmii_tx: RTL

Transmit-side Ethernet framer for the timelyRV packet path. Accepts the 134-bit flit stream emitted by the packet-processing block (head/body/tail tagged, 16 bytes per flit) and buffers whole packets in a store-and-forward FIFO. Serialises each packet onto an 8-bit GMII transmit interface, adding preamble/SFD, zero padding to the minimum frame size, CRC-32 FCS and inter-frame gap. Sits between the packet processor's `data_out` and the MAC/PHY pins.

---
 rtl/pkt_pkg.sv | 30 +++
 rtl/fifo_134b_512.sv | 60 ++++++
 rtl/pkt_gmii_tx_crc32_d8.sv | 25 ++
 rtl/pkt_gmii_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_pkg.sv
// Shared definitions for the transmit packet path.
// Holds the flit tag encodings, GMII framing bytes, CRC-32 constants and
// the transmit FSM state encoding. Imported with: import pkt_pkg::*;
package pkt_pkg;

    // Flit tags carried in data_in[133:132]
    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_BODY = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    // GMII framing bytes
    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] SFD      = 8'hD5;

    // IEEE 802.3 CRC-32, reflected form
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAD  = 3'd4,
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } tx_state_e;

endpackage

// File: rtl/fifo_134b_512.sv
// 512 x 134 synchronous FIFO, standard (non-FWFT) read mode.
// Ports:
//   clk        in   clock
//   srst       in   synchronous clear, active-high
//   din        in   write data
//   wr_en      in   write strobe, ignored when full
//   rd_en      in   read strobe, ignored when empty; dout updates next cycle
//   dout       out  read data, held until the next accepted read
//   full       out  no space left
//   data_count out  number of stored entries (0..512)
module fifo_134b_512 (
    input  logic         clk,
    input  logic         srst,
    input  logic [133:0] din,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic [133:0] dout,
    output logic         full,
    output logic [9:0]   data_count
);

    logic [133:0] mem [512];
    logic [8:0]   wr_ptr;
    logic [8:0]   rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign full  = data_count[9];
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && (data_count != 10'd0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            dout       <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 9'd1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 9'd1;
                dout   <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   data_count <= data_count + 10'd1;
                2'b01:   data_count <= data_count - 10'd1;
                default: data_count <= data_count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_gmii_tx_crc32_d8.sv
// Combinational CRC-32 update for one byte, LSB-first, reflected polynomial.
// Ports:
//   crc_in  in   current CRC register
//   data    in   byte entering the CRC, bit 0 first
//   crc_out out  CRC register after absorbing the byte
module crc32_d8
    import pkt_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/pkt_gmii_tx.sv
// Transmit-side Ethernet framer: store-and-forward FIFO of 134-bit flits,
// serialised onto GMII with preamble/SFD, zero padding, CRC-32 FCS and IFG.
// Ports:
//   clk, rst_n     125 MHz GMII clock, asynchronous active-low reset
//   data_in_valid  flit qualifier; the input has no ready, every valid flit
//                  is consumed (written or discarded) in the cycle it appears
//   data_in        [133:132] tag, [131:128] last byte index, [127:120] first byte
//   gmii_txd/en/er registered GMII transmit outputs (er tied low)
//   tx_pkt_cnt     frames fully transmitted, wrapping
//   drop_pkt_cnt   packets discarded on arrival, saturating
//   dbg_state      current transmit FSM state
module pkt_gmii_tx
    import pkt_pkg::*;
#(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_FRAME   = 60,
    parameter int DROP_THRESH = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         data_in_valid,
    input  logic [133:0] data_in,
    output logic [7:0]   gmii_txd,
    output logic         gmii_tx_en,
    output logic         gmii_tx_er,
    output logic [31:0]  tx_pkt_cnt,
    output logic [15:0]  drop_pkt_cnt,
    output logic [2:0]   dbg_state
);

    // IDLE always costs one idle cycle on the wire, so IFG itself is one short.
    localparam logic [3:0]  IFG_LAST = 4'(IFG_BYTES - 2);
    localparam logic [10:0] MIN_BC   = 11'(MIN_FRAME);
    localparam logic [9:0]  DROP_LIM = 10'(DROP_THRESH);

    tx_state_e    state, state_next;
    logic [3:0]   cnt;
    logic [10:0]  bc;
    logic [10:0]  bc_inc;
    logic [31:0]  crc_q, crc_next;
    logic [133:0] cur_flit;
    logic [127:0] cur_shift;
    logic         cur_is_tail;
    logic [31:0]  fcs;
    logic [7:0]   txd_d;
    logic         en_d;
    logic [7:0]   pend_cnt;
    logic         leave_idle;
    logic         drop_mode;

    logic [1:0]   in_tag;
    logic         in_head, in_cont, over;
    logic         fifo_wr, fifo_rd, fifo_full, tail_wr;
    logic [133:0] fifo_dout;
    logic [9:0]   fifo_count;

    // ---------------- input writer ----------------
    assign in_tag  = data_in[133:132];
    assign in_head = data_in_valid && (in_tag == TAG_HEAD);
    assign in_cont = data_in_valid && ((in_tag == TAG_BODY) || (in_tag == TAG_TAIL));
    assign over    = fifo_count > DROP_LIM;
    assign fifo_wr = !fifo_full && ((in_head && !over) || (in_cont && !drop_mode));
    assign tail_wr = fifo_wr && (in_tag == TAG_TAIL);

    // A head always re-decides; a partial packet left by a missing tail stays queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_mode    <= 1'b0;
            drop_pkt_cnt <= '0;
        end else if (in_head) begin
            drop_mode <= over;
            if (over && drop_pkt_cnt != 16'hffff) begin
                drop_pkt_cnt <= drop_pkt_cnt + 16'd1;
            end
        end else if (in_cont && in_tag == TAG_TAIL) begin
            drop_mode <= 1'b0;
        end
    end

    fifo_134b_512 u_fifo (
        .clk        (clk),
        .srst       (!rst_n),
        .din        (data_in),
        .wr_en      (fifo_wr),
        .rd_en      (fifo_rd),
        .dout       (fifo_dout),
        .full       (fifo_full),
        .data_count (fifo_count)
    );

    // Complete packets waiting in the FIFO
    assign leave_idle = (state == ST_IDLE) && (pend_cnt != 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt <= '0;
        end else begin
            case ({tail_wr, leave_idle})
                2'b10:   pend_cnt <= pend_cnt + 8'd1;
                2'b01:   pend_cnt <= pend_cnt - 8'd1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    assign cur_is_tail = cur_flit[133:132] == TAG_TAIL;
    assign cur_shift   = cur_flit[127:0] << {cnt, 3'b000};
    assign bc_inc      = bc + 11'd1;
    assign fcs         = ~crc_q;
    assign dbg_state   = state;
    assign gmii_tx_er  = 1'b0;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (txd_d),
        .crc_out (crc_next)
    );

    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        txd_d      = 8'h00;
        en_d       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_cnt != 8'd0) begin
                    fifo_rd    = 1'b1;
                    state_next = ST_PRE;
                end
            end
            ST_PRE: begin
                txd_d = PREAMBLE;
                en_d  = 1'b1;
                if (cnt == 4'd6) state_next = ST_SFD;
            end
            ST_SFD: begin
                txd_d      = SFD;
                en_d       = 1'b1;
                state_next = ST_DATA;
            end
            ST_DATA: begin
                txd_d = cur_shift[127:120];
                en_d  = 1'b1;
                if (!cur_is_tail) begin
                    // Fetch one byte early so dout is ready when the flit ends
                    if (cnt == 4'd14) fifo_rd = 1'b1;
                end else if (cnt == cur_flit[131:128]) begin
                    state_next = (bc_inc < MIN_BC) ? ST_PAD : ST_FCS;
                end
            end
            ST_PAD: begin
                en_d = 1'b1;
                if (bc_inc == MIN_BC) state_next = ST_FCS;
            end
            ST_FCS: begin
                en_d = 1'b1;
                case (cnt[1:0])
                    2'd0:    txd_d = fcs[7:0];
                    2'd1:    txd_d = fcs[15:8];
                    2'd2:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
                if (cnt == 4'd3) state_next = ST_IFG;
            end
            ST_IFG: begin
                if (cnt == IFG_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bc         <= '0;
            crc_q      <= '1;
            cur_flit   <= '0;
            tx_pkt_cnt <= '0;
            gmii_txd   <= '0;
            gmii_tx_en <= 1'b0;
        end else begin
            state      <= state_next;
            // cnt is the per-state cycle counter and, in DATA, the byte lane
            cnt        <= (state_next != state) ? 4'd0 : cnt + 4'd1;
            gmii_txd   <= txd_d;
            gmii_tx_en <= en_d;
            if (state == ST_PRE && cnt == 4'd0) begin
                cur_flit <= fifo_dout;
            end else if (state == ST_DATA && !cur_is_tail && cnt == 4'd15) begin
                cur_flit <= fifo_dout;
            end
            if (state == ST_SFD) begin
                crc_q <= '1;
                bc    <= '0;
            end else if (state == ST_DATA || state == ST_PAD) begin
                crc_q <= crc_next;
                bc    <= bc_inc;
            end
            if (state == ST_FCS && state_next == ST_IFG) begin
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
            end
        end
    end

endmodule
